pre_sc_hist: RTL and testbench
==============================

// Module: pre_sc_hist
// PURPOSE
//  Parametrised byte-history register for the flash serial front end. Captures the last DEPTH
//  received bytes per frame, tracks per-entry validity and a saturating byte count, and flags
//  header completion (command + address) so the command decoder need not count bytes itself.
//  Sits between the SPI deserialiser (byte + valid strobe) and the command/address decoder.
// PARAMETERS
//  DATA_W      8   width of one received byte/word
//  DEPTH       4   history entries; entry 0 = newest (DEPTH >= 2)
//  HDR_LEN     4   bytes forming the frame header (1 command + 3 address); 1 <= HDR_LEN <= DEPTH
//  FREEZE_HDR  1   1: history stops shifting once HDR_LEN bytes are captured; 0: always shifts
//  CNT_W       8   width of byte_cnt; saturates at 2**CNT_W-1
// PORTS
//  sck           in   1             clock; all state updates on rising edge
//  rst           in   1             asynchronous, active-high reset
//  frame_start   in   1             synchronous frame clear (chip-select assertion), one-cycle pulse
//  data_byte_in  in   DATA_W        received byte
//  data_in_valid in   1             data_byte_in valid this cycle
//  hist_data     out  DEPTH*DATA_W  history, entry i at [i*DATA_W +: DATA_W], entry 0 newest
//  hist_valid    out  DEPTH         bit i set when entry i holds a byte of the current frame
//  byte_cnt      out  CNT_W         bytes accepted in current frame, saturating
//  hdr_done      out  1             level: HDR_LEN bytes of current frame received
//  hdr_pulse     out  1             one-cycle pulse in the cycle after the HDR_LEN-th byte is accepted
//  hdr_word      out  HDR_LEN*DATA_W header, first received byte in MSBs; stable while hdr_done=1
// BEHAVIOUR
//  - Reset (rst=1, async): hist_data=0, hist_valid=0, byte_cnt=0, hdr_done=0, hdr_pulse=0, hdr_word=0.
//  - Accept: data_in_valid=1 -> entry i <= entry i-1 (i>=1), entry 0 <= data_byte_in,
//    hist_valid <= {hist_valid[DEPTH-2:0],1'b1}; byte_cnt += 1 unless at max. Latency 1 cycle.
//  - No valid: all state holds; hdr_pulse=0.
//  - Oldest entry is discarded on shift; no overflow flag.
//  - Header: when the accepted byte makes byte_cnt reach HDR_LEN, next cycle hdr_done=1,
//    hdr_pulse=1 (single cycle), hdr_word = entries HDR_LEN-1..0 concatenated (oldest in MSBs).
//    hdr_word registered at that moment and held until frame_start or rst.
//  - FREEZE_HDR=1: after hdr_done, further valids do not shift history; byte_cnt still counts.
//    FREEZE_HDR=0: history keeps shifting; hdr_word still holds the captured header.
//  - frame_start alone: hist_valid=0, byte_cnt=0, hdr_done=0, hdr_word=0; hist_data cleared to 0.
//  - frame_start with data_in_valid same cycle: clear first, then accept byte as first of new frame:
//    entry 0=byte, others 0, hist_valid=1, byte_cnt=1; if HDR_LEN=1 hdr_done/hdr_pulse set next cycle.
//  - byte_cnt saturation: holds at max; hdr_done never re-pulses within a frame.
//  - rst mid-frame: immediate return to reset values regardless of sck.
// STRUCTURE
//  - Shared package flash_pkg: FLASH_DATA_W=8, FLASH_HDR_LEN=4 (cmd + 24-bit address) constants,
//    used as parameter defaults here and by the command decoder.
//  - One sub-module: pre_sc_sat_cnt (CNT_W saturating counter with sync clear/inc, async rst).
//  - Shift array and header capture live in this module; no FSM beyond the hdr_done flag.
// TESTING
//  1 rst=1 mid-traffic -> all outputs 0 within same cycle; deassert, idle -> outputs stay 0.
//  2 frame_start, then bytes 03,12,34,56 -> hdr_pulse once after 56, hdr_word=0x03123456, byte_cnt=4.
//  3 FREEZE_HDR=1, after test 2 send 9A,BC -> hist_data unchanged (entry0=56), byte_cnt=6;
//    FREEZE_HDR=0 same stimulus -> entry0=BC, entry1=9A, hdr_word still 0x03123456.
//  4 frame_start with valid byte 0B same cycle -> entry0=0B, hist_valid=0001, byte_cnt=1, hdr_done=0.
//  5 gaps: bytes with data_in_valid low between them -> history/byte_cnt change only on valid cycles.
//  6 CNT_W=3, 10 bytes -> byte_cnt saturates at 7, hdr_pulse seen exactly once.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared constants for the flash serial front end and command decoder.
package flash_pkg;

  localparam int FLASH_DATA_W  = 32'd8;
  // One command byte followed by a 24-bit address.
  localparam int FLASH_HDR_LEN = 32'd4;

endpackage : flash_pkg

// File: rtl/pre_sc_sat_cnt.sv
// Saturating up-counter with synchronous clear/increment and async active-high reset.
module pre_sc_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over hold; an increment in the clear cycle counts as the first event.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      if (inc_i) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pre_sc_sat_cnt

// File: rtl/pre_sc_hist.sv
// Byte-history register for the flash serial front end: keeps the last DEPTH bytes of a
// frame, a saturating byte count, and captures the command/address header once complete.
module pre_sc_hist
  import flash_pkg::*;
#(
  parameter int DATA_W     = FLASH_DATA_W,
  parameter int DEPTH      = 4,
  parameter int HDR_LEN    = FLASH_HDR_LEN,
  parameter bit FREEZE_HDR = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic                      sck,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [DATA_W-1:0]         data_byte_in,
  input  logic                      data_in_valid,
  output logic [DEPTH*DATA_W-1:0]   hist_data,
  output logic [DEPTH-1:0]          hist_valid,
  output logic [CNT_W-1:0]          byte_cnt,
  output logic                      hdr_done,
  output logic                      hdr_pulse,
  output logic [HDR_LEN*DATA_W-1:0] hdr_word
);

  localparam logic [CNT_W-1:0] HDR_CNT_M1 = CNT_W'(HDR_LEN - 1);
  localparam bit               HDR_ONE    = (HDR_LEN == 1);

  logic [DEPTH*DATA_W-1:0]   hist_q, hist_d, hist_base;
  logic [DEPTH-1:0]          hvalid_q, hvalid_d, hvalid_base;
  logic                      hdr_done_q, hdr_done_d;
  logic                      hdr_pulse_q, hdr_pulse_d;
  logic [HDR_LEN*DATA_W-1:0] hdr_word_q, hdr_word_d;
  logic                      frozen, shift_en, hdr_hit;
  logic [CNT_W-1:0]          cnt;

  pre_sc_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (sck),
    .rst_i (rst),
    .clr_i (frame_start),
    .inc_i (data_in_valid),
    .cnt_o (cnt)
  );

  // frame_start clears first so a same-cycle byte lands as the first of the new frame.
  always_comb begin
    hist_base   = frame_start ? '0 : hist_q;
    hvalid_base = frame_start ? '0 : hvalid_q;
    frozen      = FREEZE_HDR && hdr_done_q && !frame_start;
    shift_en    = data_in_valid && !frozen;

    hist_d   = hist_base;
    hvalid_d = hvalid_base;
    if (shift_en) begin
      hist_d   = {hist_base[(DEPTH-1)*DATA_W-1:0], data_byte_in};
      hvalid_d = {hvalid_base[DEPTH-2:0], 1'b1};
    end else begin
      hist_d   = hist_base;
      hvalid_d = hvalid_base;
    end

    if (frame_start) begin
      hdr_hit = data_in_valid && HDR_ONE;
    end else begin
      hdr_hit = data_in_valid && !hdr_done_q && (cnt == HDR_CNT_M1);
    end

    hdr_pulse_d = hdr_hit;
    hdr_done_d  = frame_start ? hdr_hit : (hdr_done_q || hdr_hit);

    // Newest HDR_LEN entries after the shift; oldest byte lands in the MSBs.
    if (hdr_hit) begin
      hdr_word_d = hist_d[HDR_LEN*DATA_W-1:0];
    end else if (frame_start) begin
      hdr_word_d = '0;
    end else begin
      hdr_word_d = hdr_word_q;
    end
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      hist_q      <= '0;
      hvalid_q    <= '0;
      hdr_done_q  <= 1'b0;
      hdr_pulse_q <= 1'b0;
      hdr_word_q  <= '0;
    end else begin
      hist_q      <= hist_d;
      hvalid_q    <= hvalid_d;
      hdr_done_q  <= hdr_done_d;
      hdr_pulse_q <= hdr_pulse_d;
      hdr_word_q  <= hdr_word_d;
    end
  end

  assign hist_data  = hist_q;
  assign hist_valid = hvalid_q;
  assign byte_cnt   = cnt;
  assign hdr_done   = hdr_done_q;
  assign hdr_pulse  = hdr_pulse_q;
  assign hdr_word   = hdr_word_q;

endmodule : pre_sc_hist

// File: tb/tb_pre_sc_hist.sv
// Self-checking bench: three pre_sc_hist variants (freeze, no-freeze, 3-bit counter) driven
// by shared stimulus and compared with a frame-level reference model.
module tb_pre_sc_hist;

  logic       sck = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       data_in_valid = 1'b0;
  logic [7:0] data_byte_in = 8'h00;

  logic [31:0] hist_f, hist_n, hist_s;
  logic [3:0]  hv_f, hv_n, hv_s;
  logic [7:0]  cnt_f, cnt_n;
  logic [2:0]  cnt_s;
  logic        done_f, done_n, done_s;
  logic        pulse_f, pulse_n, pulse_s;
  logic [31:0] hw_f, hw_n, hw_s;

  int passed = 0;
  int total  = 0;

  always #5 sck = ~sck;

  pre_sc_hist #(.FREEZE_HDR(1'b1), .CNT_W(8)) dut_f (
    .sck(sck), .rst(rst), .frame_start(frame_start), .data_byte_in(data_byte_in),
    .data_in_valid(data_in_valid), .hist_data(hist_f), .hist_valid(hv_f), .byte_cnt(cnt_f),
    .hdr_done(done_f), .hdr_pulse(pulse_f), .hdr_word(hw_f));

  pre_sc_hist #(.FREEZE_HDR(1'b0), .CNT_W(8)) dut_n (
    .sck(sck), .rst(rst), .frame_start(frame_start), .data_byte_in(data_byte_in),
    .data_in_valid(data_in_valid), .hist_data(hist_n), .hist_valid(hv_n), .byte_cnt(cnt_n),
    .hdr_done(done_n), .hdr_pulse(pulse_n), .hdr_word(hw_n));

  pre_sc_hist #(.FREEZE_HDR(1'b1), .CNT_W(3)) dut_s (
    .sck(sck), .rst(rst), .frame_start(frame_start), .data_byte_in(data_byte_in),
    .data_in_valid(data_in_valid), .hist_data(hist_s), .hist_valid(hv_s), .byte_cnt(cnt_s),
    .hdr_done(done_s), .hdr_pulse(pulse_s), .hdr_word(hw_s));

  // Reference model: every byte of the current frame, in arrival order.
  logic [7:0] fq[$];
  int         n = 0;
  bit         m_pulse = 1'b0;

  function automatic int eff_len(bit frz);
    int ne = n;
    if (frz && ne > 4) ne = 4;
    return ne;
  endfunction

  function automatic logic [31:0] exp_hist(bit frz);
    logic [31:0] r = 32'h0;
    int ne = eff_len(frz);
    for (int i = 0; i < 4; i++)
      if (i < ne) r[i*8 +: 8] = fq[ne-1-i];
    return r;
  endfunction

  function automatic logic [3:0] exp_valid(bit frz);
    logic [3:0] r = 4'h0;
    int ne = eff_len(frz);
    for (int i = 0; i < 4; i++)
      if (i < ne) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_hdr();
    if (n >= 4) return {fq[0], fq[1], fq[2], fq[3]};
    return 32'h0;
  endfunction

  task automatic model_clear();
    fq.delete();
    n = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_update(input logic fs, input logic v, input logic [7:0] b);
    if (fs) model_clear();
    m_pulse = 1'b0;
    if (v) begin
      fq.push_back(b);
      n++;
      if (n == 4) m_pulse = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic check_model();
    chk("f.hist",  64'(hist_f), 64'(exp_hist(1'b1)));
    chk("f.valid", 64'(hv_f),   64'(exp_valid(1'b1)));
    chk("f.cnt",   64'(cnt_f),  64'((n > 255) ? 255 : n));
    chk("f.done",  64'(done_f), 64'(n >= 4));
    chk("f.pulse", 64'(pulse_f), 64'(m_pulse));
    chk("f.hword", 64'(hw_f),   64'(exp_hdr()));
    chk("n.hist",  64'(hist_n), 64'(exp_hist(1'b0)));
    chk("n.valid", 64'(hv_n),   64'(exp_valid(1'b0)));
    chk("n.cnt",   64'(cnt_n),  64'((n > 255) ? 255 : n));
    chk("n.done",  64'(done_n), 64'(n >= 4));
    chk("n.pulse", 64'(pulse_n), 64'(m_pulse));
    chk("n.hword", 64'(hw_n),   64'(exp_hdr()));
    chk("s.hist",  64'(hist_s), 64'(exp_hist(1'b1)));
    chk("s.cnt",   64'(cnt_s),  64'((n > 7) ? 7 : n));
    chk("s.done",  64'(done_s), 64'(n >= 4));
    chk("s.pulse", 64'(pulse_s), 64'(m_pulse));
    chk("s.hword", 64'(hw_s),   64'(exp_hdr()));
  endtask

  task automatic step(input logic fs, input logic v, input logic [7:0] b);
    frame_start   = fs;
    data_in_valid = v;
    data_byte_in  = b;
    @(posedge sck);
    model_update(fs, v, b);
    #1;
    frame_start   = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".hist"}, 64'({hist_f, hist_n, hist_s}), 64'h0);
    chk({tag, ".valid"}, 64'({hv_f, hv_n, hv_s}), 64'h0);
    chk({tag, ".cnt"}, 64'({cnt_f, cnt_n, cnt_s}), 64'h0);
    chk({tag, ".flags"}, 64'({done_f, done_n, done_s, pulse_f, pulse_n, pulse_s}), 64'h0);
    chk({tag, ".hword"}, 64'({hw_f, hw_n, hw_s}), 64'h0);
  endtask

  typedef struct {
    logic        fs;
    logic        v;
    logic [7:0]  b;
    logic [7:0]  cnt;
    logic [31:0] hist_f;
    logic [31:0] hist_n;
    logic [3:0]  hv;
    logic        done;
    logic        pulse;
    logic [31:0] hword;
  } vec_t;

  vec_t tbl[11];
  int   pulses;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'd0, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 8'h03, 8'd1, 32'h00000003, 32'h00000003, 4'b0001, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 8'h12, 8'd2, 32'h00000312, 32'h00000312, 4'b0011, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 8'hEE, 8'd2, 32'h00000312, 32'h00000312, 4'b0011, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 8'h34, 8'd3, 32'h00031234, 32'h00031234, 4'b0111, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 8'h56, 8'd4, 32'h03123456, 32'h03123456, 4'b1111, 1'b1, 1'b1, 32'h03123456};
    tbl[6]  = '{1'b0, 1'b0, 8'h77, 8'd4, 32'h03123456, 32'h03123456, 4'b1111, 1'b1, 1'b0, 32'h03123456};
    tbl[7]  = '{1'b0, 1'b1, 8'h9A, 8'd5, 32'h03123456, 32'h1234569A, 4'b1111, 1'b1, 1'b0, 32'h03123456};
    tbl[8]  = '{1'b0, 1'b1, 8'hBC, 8'd6, 32'h03123456, 32'h34569ABC, 4'b1111, 1'b1, 1'b0, 32'h03123456};
    tbl[9]  = '{1'b1, 1'b1, 8'h0B, 8'd1, 32'h0000000B, 32'h0000000B, 4'b0001, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 8'd0, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h0};

    // Power-on reset.
    #1;
    check_zero("por");
    repeat (2) @(posedge sck);
    #1;
    rst = 1'b0;
    model_clear();

    // Asynchronous reset mid-traffic, then idle.
    step(1'b1, 1'b1, 8'hAA);
    step(1'b0, 1'b1, 8'hBB);
    check_model();
    #3;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    model_clear();
    @(posedge sck);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00);
      check_zero("rst_idle");
    end

    // Directed table: header capture, freeze vs shift, same-cycle frame_start, gaps.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].fs, tbl[i].v, tbl[i].b);
      chk($sformatf("tbl%0d.cnt", i),    64'(cnt_f),   64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.hist_f", i), 64'(hist_f),  64'(tbl[i].hist_f));
      chk($sformatf("tbl%0d.hist_n", i), 64'(hist_n),  64'(tbl[i].hist_n));
      chk($sformatf("tbl%0d.valid", i),  64'(hv_f),    64'(tbl[i].hv));
      chk($sformatf("tbl%0d.done", i),   64'(done_f),  64'(tbl[i].done));
      chk($sformatf("tbl%0d.pulse", i),  64'(pulse_f), 64'(tbl[i].pulse));
      chk($sformatf("tbl%0d.hword_f", i), 64'(hw_f),   64'(tbl[i].hword));
      chk($sformatf("tbl%0d.hword_n", i), 64'(hw_n),   64'(tbl[i].hword));
      check_model();
    end

    // Saturation on the 3-bit counter: ten bytes, one header pulse.
    pulses = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'(8'h40 + i));
      pulses += int'(pulse_s);
      check_model();
    end
    step(1'b0, 1'b0, 8'h00);
    pulses += int'(pulse_s);
    chk("sat.cnt", 64'(cnt_s), 64'd7);
    chk("sat.pulse_once", 64'(pulses), 64'd1);
    chk("sat.hword", 64'(hw_s), 64'h40414243);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
      check_model();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_pre_sc_hist
